regfile_wb_arbiter: RTL

Shares the single write port of the 32x32 register file among `NUM_REQ` writeback requesters, for example the ALU, the load unit and the multicycle mul/div unit. Arbitration is round-robin with a valid/ready handshake. Grants are registered into a one-deep output stage that drives the register file's `write_enable`, `write_address` and `write_data`. Writes to x0 are consumed without a register file write. A busy mask of the in-flight destination is exported for hazard checks.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ
// writeback requesters, with a one-deep registered output stage.
module regfile_wb_arbiter #(
   parameter int unsigned NUM_REQ = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [5*NUM_REQ-1:0]   req_addr,
   input  logic [32*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic                   lock,
   output logic                   wb_enable,
   output logic [4:0]             wb_address,
   output logic [31:0]            wb_data,
   output logic [31:0]            busy_mask,
   output logic [2:0]             grant_idx
);

   localparam int unsigned PTR_W  = 3;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;

   logic [PTR_W-1:0]   r_rr_ptr;
   logic               r_wb_enable;
   logic [ADDR_W-1:0]  r_wb_address;
   logic [DATA_W-1:0]  r_wb_data;
   logic [31:0]        r_busy_mask;
   logic [PTR_W-1:0]   r_grant_idx;

   logic               w_found;
   logic [PTR_W-1:0]   w_gnt_idx;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_data;
   logic [PTR_W-1:0]   w_next_ptr;
   logic [NUM_REQ-1:0] w_ready;

   // Two-pass search: first pass from rr_ptr upward, second pass wraps from 0
   always_comb begin
      w_found    = 1'b0;
      w_gnt_idx  = '0;
      w_sel_addr = '0;
      w_sel_data = '0;
      if (rst && !lock) begin
         for (int unsigned p = 0; p < 2; p++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
               if (!w_found && req_valid[i] && ((p == 1) || (i >= 32'(r_rr_ptr)))) begin
                  w_found    = 1'b1;
                  w_gnt_idx  = PTR_W'(i);
                  w_sel_addr = req_addr[ADDR_W*i +: ADDR_W];
                  w_sel_data = req_data[DATA_W*i +: DATA_W];
               end
            end
         end
      end
   end

   // One-hot ready for the winner and pointer advance past it
   always_comb begin
      w_ready    = '0;
      w_next_ptr = r_rr_ptr;
      if (w_found) begin
         w_ready = NUM_REQ'(1) << w_gnt_idx;
         if (w_gnt_idx == PTR_W'(NUM_REQ - 1)) begin
            w_next_ptr = '0;
         end else begin
            w_next_ptr = w_gnt_idx + PTR_W'(1);
         end
      end
   end

   // Output stage: x0 writes are handshaken but never enable the register file
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr     <= '0;
         r_wb_enable  <= 1'b0;
         r_wb_address <= '0;
         r_wb_data    <= '0;
         r_busy_mask  <= '0;
         r_grant_idx  <= '0;
      end else begin
         r_wb_enable <= w_found && (w_sel_addr != '0);
         r_busy_mask <= (w_found && (w_sel_addr != '0)) ? (32'(1) << w_sel_addr) : 32'(0);
         if (w_found) begin
            r_rr_ptr     <= w_next_ptr;
            r_wb_address <= w_sel_addr;
            r_wb_data    <= w_sel_data;
            r_grant_idx  <= w_gnt_idx;
         end
      end
   end

   assign req_ready  = w_ready;
   assign wb_enable  = r_wb_enable;
   assign wb_address = r_wb_address;
   assign wb_data    = r_wb_data;
   assign busy_mask  = r_busy_mask;
   assign grant_idx  = r_grant_idx;

endmodule
